// File: rtl/reg_arb_tmo_pkg.sv
// Shared types for the register-interface arbiter with stall timeout:
// FSM state encoding, default request/response structs and pointer wrap helper.
package reg_arb_tmo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] rdata;
    } reg_rsp_t;

    // Increment modulo n; with n == 1 the result is always 0.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/reg_arb_tmo_rr.sv
// Combinational round-robin picker: first valid requester at or after the
// pointer, wrapping modulo NumReq.
module reg_arb_tmo_rr #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = 1
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o
);

    always_comb begin
        int unsigned c;
        logic [IdxW-1:0] cand;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            c = 32'(ptr_i) + k;
            if (c >= NumReq) c = c - NumReq;
            cand = IdxW'(c);
            if (!found && valid_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/reg_arb_tmo.sv
// N:1 register-interface arbiter with round-robin fairness, grant locking
// across downstream stalls, and an optional stall timeout that aborts with ErrVal.
module reg_arb_tmo
    import reg_arb_tmo_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned DW            = 32,
    parameter int unsigned TimeoutCycles = 0,
    parameter logic [DW-1:0] ErrVal      = '0,
    parameter type req_t                 = reg_req_t,
    parameter type rsp_t                 = reg_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  req_t [NumReq-1:0]     req_i,
    output rsp_t [NumReq-1:0]     rsp_o,
    output req_t                  req_o,
    input  rsp_t                  rsp_i,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0] timeout_idx_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] TmoVal = CntW'(TimeoutCycles);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   lock_q, lock_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [NumReq-1:0] valid;
    logic [NumReq-1:0] gnt;
    logic [IdxW-1:0]   win;
    logic              any;

    function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] v);
        return IdxW'(wrap_inc(32'(v), NumReq));
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) valid[i] = req_i[i].valid;
    end

    reg_arb_tmo_rr #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr (
        .valid_i (valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (win)
    );

    assign any = |gnt;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        req_o   = '0;
        rsp_o   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    req_o      = req_i[win];
                    rsp_o[win] = rsp_i;
                    if (rsp_i.ready) begin
                        ptr_d = next_ptr(win);
                    end else begin
                        lock_d  = win;
                        cnt_d   = CntW'(1);
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // Grant stays with the locked index even if its valid drops.
                req_o         = req_i[lock_q];
                rsp_o[lock_q] = rsp_i;
                if (rsp_i.ready) begin
                    ptr_d   = next_ptr(lock_q);
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (TimeoutCycles != 0 && cnt_q == TmoVal) begin
                    state_d = ST_ABORT;
                end else if (cnt_q != {CntW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ABORT: begin
                rsp_o[lock_q].ready = 1'b1;
                rsp_o[lock_q].error = 1'b1;
                rsp_o[lock_q].rdata = ErrVal;
                ptr_d   = next_ptr(lock_q);
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign timeout_o     = (state_q == ST_ABORT);
    assign timeout_idx_o = (state_q == ST_ABORT) ? lock_q : '0;

endmodule

// File: tb/tb_reg_arb_tmo.sv
// Directed bench for reg_arb_tmo with three requesters and a 4-cycle timeout.
module tb_reg_arb_tmo;
    import reg_arb_tmo_pkg::*;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0104;
    localparam logic [31:0] A2 = 32'h0000_0108;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    reg_req_t [2:0] req_i;
    reg_rsp_t [2:0] rsp_o;
    reg_req_t       req_o;
    reg_rsp_t       rsp_i;
    logic           busy_o;
    logic           timeout_o;
    logic [1:0]     timeout_idx_o;

    int n_tests = 0;
    int n_fail  = 0;

    reg_arb_tmo #(
        .NumReq        (3),
        .DW            (32),
        .TimeoutCycles (4),
        .ErrVal        (32'hBADCAB1E),
        .req_t         (reg_req_t),
        .rsp_t         (reg_rsp_t)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .rsp_o         (rsp_o),
        .req_o         (req_o),
        .rsp_i         (rsp_i),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o),
        .timeout_idx_o (timeout_idx_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a);
        req_i[i]       = '0;
        req_i[i].valid = v;
        req_i[i].addr  = a;
    endtask

    task automatic set_rsp(input logic rdy, input logic [31:0] d);
        rsp_i       = '0;
        rsp_i.ready = rdy;
        rsp_i.rdata = d;
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        req_i = '0;
        rsp_i = '0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_tmo", timeout_o, 0);
        chk("rst_tmo_idx", timeout_idx_o, 0);
        chk("rst_req_o", req_o, 0);

        // Round-robin with all requesters valid and downstream always ready.
        tick();
        rst_ni = 1'b1;
        set_req(0, 1, A0); set_req(1, 1, A1); set_req(2, 1, A2);
        set_rsp(1, 32'hA5A5_0000);
        #1;
        chk("rr0_addr", req_o.addr, A0);
        chk("rr0_rdy0", rsp_o[0].ready, 1);
        chk("rr0_rdy1", rsp_o[1].ready, 0);
        chk("rr0_rdata", rsp_o[0].rdata, 32'hA5A5_0000);
        chk("rr0_busy", busy_o, 0);
        tick(); #1;
        chk("rr1_addr", req_o.addr, A1);
        chk("rr1_rdy1", rsp_o[1].ready, 1);
        chk("rr1_rdy0", rsp_o[0].ready, 0);
        tick(); #1;
        chk("rr2_addr", req_o.addr, A2);
        chk("rr2_rdy2", rsp_o[2].ready, 1);
        tick(); #1;
        chk("rr3_addr", req_o.addr, A0);
        chk("rr3_rdy0", rsp_o[0].ready, 1);

        // Three stall cycles then ready; pointer is now 1.
        tick();
        set_req(0, 0, 0); set_req(1, 1, A1); set_req(2, 0, 0);
        set_rsp(0, 0);
        #1;
        chk("idle_req_o", req_o.valid, 1);
        chk("st0_busy", busy_o, 0);
        chk("st0_rdy1", rsp_o[1].ready, 0);
        tick(); #1;
        chk("st1_busy", busy_o, 1);
        tick();
        set_req(0, 1, A0);
        #1;
        chk("st2_busy", busy_o, 1);
        chk("st2_lock_addr", req_o.addr, A1);
        chk("st2_rdy0", rsp_o[0].ready, 0);
        tick();
        set_req(0, 0, 0);
        set_rsp(1, 32'h1234_5678);
        #1;
        chk("st3_busy", busy_o, 1);
        chk("st3_rdy1", rsp_o[1].ready, 1);
        chk("st3_rdata", rsp_o[1].rdata, 32'h1234_5678);
        chk("st3_err", rsp_o[1].error, 0);
        chk("st3_tmo", timeout_o, 0);
        tick();
        set_req(1, 0, 0);
        set_rsp(0, 0);
        #1;
        chk("st4_busy", busy_o, 0);
        chk("st4_tmo", timeout_o, 0);

        // Downstream never ready: abort in cycle 5; pointer is now 2.
        tick();
        set_req(1, 1, A1);
        for (int c = 1; c <= 4; c++) tick();
        #1;
        chk("to4_busy", busy_o, 1);
        chk("to4_tmo", timeout_o, 0);
        chk("to4_valid", req_o.valid, 1);
        tick(); #1;
        chk("to5_rdy1", rsp_o[1].ready, 1);
        chk("to5_err", rsp_o[1].error, 1);
        chk("to5_rdata", rsp_o[1].rdata, 32'hBADCAB1E);
        chk("to5_tmo", timeout_o, 1);
        chk("to5_idx", timeout_idx_o, 1);
        chk("to5_valid", req_o.valid, 0);
        chk("to5_busy", busy_o, 1);
        chk("to5_rdy0", rsp_o[0].ready, 0);
        tick();
        set_req(1, 0, 0);
        #1;
        chk("to6_tmo", timeout_o, 0);
        chk("to6_idx", timeout_idx_o, 0);
        chk("to6_busy", busy_o, 0);

        // Ready exactly in stall cycle 4 completes normally.
        tick();
        set_req(2, 1, A2);
        for (int c = 1; c <= 4; c++) tick();
        set_rsp(1, 32'hCAFE_0004);
        #1;
        chk("edge4_rdy2", rsp_o[2].ready, 1);
        chk("edge4_err", rsp_o[2].error, 0);
        chk("edge4_rdata", rsp_o[2].rdata, 32'hCAFE_0004);
        chk("edge4_tmo", timeout_o, 0);
        tick();
        set_req(2, 0, 0);
        set_rsp(0, 0);
        #1;
        chk("edge5_tmo", timeout_o, 0);
        chk("edge5_busy", busy_o, 0);

        // Move pointer to 1, lock requester 1, then reset while BUSY.
        tick();
        set_req(0, 1, A0);
        set_rsp(1, 32'h0);
        #1;
        chk("pre_addr", req_o.addr, A0);
        tick();
        set_req(0, 0, 0); set_req(1, 1, A1);
        set_rsp(0, 0);
        tick(); #1;
        chk("pre_rst_busy", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_rdy1", rsp_o[1].ready, 0);
        chk("rst_mid_tmo", timeout_o, 0);
        tick();
        rst_ni = 1'b1;
        set_req(0, 1, A0); set_req(1, 1, A1); set_req(2, 1, A2);
        set_rsp(1, 32'h0);
        #1;
        chk("post_rst_addr", req_o.addr, A0);
        chk("post_rst_rdy1", rsp_o[1].ready, 0);
        tick(); #1;
        chk("post_rst_addr2", req_o.addr, A1);
        tick();
        req_i = '0;
        set_rsp(0, 0);
        #1;
        chk("final_req_o", req_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
